// File: rtl/ps2_pkg.sv
// ps2_pkg: shared scancode, parser-state and ASCII constants for the PS/2 key decoder
package ps2_pkg;
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_PAUSE  = 8'hE1;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_BREAK     = 2'd1;
    localparam logic [1:0] S_EXT       = 2'd2;
    localparam logic [1:0] S_EXT_BREAK = 2'd3;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_BS = 8'h08;
    localparam logic [7:0] ASCII_SP = 8'h20;
    function automatic logic is_ctrl(input logic [7:0] b);
        return b inside {SC_BREAK, SC_EXT, SC_PAUSE, SC_LSHIFT, SC_RSHIFT, SC_CAPS};
    endfunction
endpackage

// File: rtl/scancode_to_ascii.sv
// scancode_to_ascii: combinational set-2 scancode to ASCII table, 00 for unmapped codes
module scancode_to_ascii
    import ps2_pkg::*;
(
    input  logic [7:0] i_code,
    input  logic       i_shift,
    input  logic       i_caps,
    output logic [7:0] o_ascii
);
    logic [15:0] w_pair;
    logic        w_letter;
    // Each entry is {unshifted, shifted}
    always_comb begin
        w_pair = 16'h0000;
        case (i_code)
            8'h1C: w_pair = {8'h61, 8'h41};
            8'h32: w_pair = {8'h62, 8'h42};
            8'h21: w_pair = {8'h63, 8'h43};
            8'h23: w_pair = {8'h64, 8'h44};
            8'h24: w_pair = {8'h65, 8'h45};
            8'h2B: w_pair = {8'h66, 8'h46};
            8'h34: w_pair = {8'h67, 8'h47};
            8'h33: w_pair = {8'h68, 8'h48};
            8'h43: w_pair = {8'h69, 8'h49};
            8'h3B: w_pair = {8'h6A, 8'h4A};
            8'h42: w_pair = {8'h6B, 8'h4B};
            8'h4B: w_pair = {8'h6C, 8'h4C};
            8'h3A: w_pair = {8'h6D, 8'h4D};
            8'h31: w_pair = {8'h6E, 8'h4E};
            8'h44: w_pair = {8'h6F, 8'h4F};
            8'h4D: w_pair = {8'h70, 8'h50};
            8'h15: w_pair = {8'h71, 8'h51};
            8'h2D: w_pair = {8'h72, 8'h52};
            8'h1B: w_pair = {8'h73, 8'h53};
            8'h2C: w_pair = {8'h74, 8'h54};
            8'h3C: w_pair = {8'h75, 8'h55};
            8'h2A: w_pair = {8'h76, 8'h56};
            8'h1D: w_pair = {8'h77, 8'h57};
            8'h22: w_pair = {8'h78, 8'h58};
            8'h35: w_pair = {8'h79, 8'h59};
            8'h1A: w_pair = {8'h7A, 8'h5A};
            8'h16: w_pair = {8'h31, 8'h21};
            8'h1E: w_pair = {8'h32, 8'h40};
            8'h26: w_pair = {8'h33, 8'h23};
            8'h25: w_pair = {8'h34, 8'h24};
            8'h2E: w_pair = {8'h35, 8'h25};
            8'h36: w_pair = {8'h36, 8'h5E};
            8'h3D: w_pair = {8'h37, 8'h26};
            8'h3E: w_pair = {8'h38, 8'h2A};
            8'h46: w_pair = {8'h39, 8'h28};
            8'h45: w_pair = {8'h30, 8'h29};
            8'h0E: w_pair = {8'h60, 8'h7E};
            8'h4E: w_pair = {8'h2D, 8'h5F};
            8'h55: w_pair = {8'h3D, 8'h2B};
            8'h54: w_pair = {8'h5B, 8'h7B};
            8'h5B: w_pair = {8'h5D, 8'h7D};
            8'h5D: w_pair = {8'h5C, 8'h7C};
            8'h4C: w_pair = {8'h3B, 8'h3A};
            8'h52: w_pair = {8'h27, 8'h22};
            8'h41: w_pair = {8'h2C, 8'h3C};
            8'h49: w_pair = {8'h2E, 8'h3E};
            8'h4A: w_pair = {8'h2F, 8'h3F};
            8'h29: w_pair = {ASCII_SP, ASCII_SP};
            8'h5A: w_pair = {ASCII_CR, ASCII_CR};
            8'h66: w_pair = {ASCII_BS, ASCII_BS};
            default: w_pair = 16'h0000;
        endcase
    end
    assign w_letter = (w_pair[15:8] >= 8'h61) && (w_pair[15:8] <= 8'h7A);
    assign o_ascii  = (w_letter ? (i_shift ^ i_caps) : i_shift) ? w_pair[7:0] : w_pair[15:8];
endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 set-2 prefix parser with shift/caps tracking feeding an ASCII FIFO
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_AW    = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         rx_data,
    input  logic               rx_strobe,
    input  logic               rx_err,
    output logic [7:0]         char_data,
    output logic               char_valid,
    input  logic               char_ready,
    output logic               shift_active,
    output logic               caps_active,
    output logic               overflow,
    output logic [FIFO_AW:0]   fifo_count
);
    localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(FIFO_DEPTH);
    logic [1:0]         r_state;
    logic [7:0]         r_byte;
    logic               r_make;
    logic               r_lshift;
    logic               r_rshift;
    logic               r_caps;
    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] r_wr;
    logic [FIFO_AW-1:0] r_rd;
    logic [FIFO_AW:0]   r_count;
    logic               w_accept;
    logic [7:0]         w_ascii;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_write;
    assign w_accept = rx_strobe & ~rx_err;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_byte   <= 8'h00;
            r_make   <= 1'b0;
            r_lshift <= 1'b0;
            r_rshift <= 1'b0;
            r_caps   <= 1'b0;
        end else begin
            r_make <= 1'b0;
            if (rx_strobe && rx_err) begin
                r_state <= S_IDLE;
            end else if (w_accept) begin
                case (r_state)
                    S_IDLE: begin
                        r_state <= (rx_data == SC_BREAK) ? S_BREAK : (rx_data == SC_EXT) ? S_EXT : S_IDLE;
                        r_byte  <= rx_data;
                        r_make  <= !is_ctrl(rx_data);
                        if (rx_data == SC_LSHIFT) r_lshift <= 1'b1;
                        if (rx_data == SC_RSHIFT) r_rshift <= 1'b1;
                        if (rx_data == SC_CAPS) r_caps <= ~r_caps;
                    end
                    S_BREAK: begin
                        r_state <= S_IDLE;
                        if (rx_data == SC_LSHIFT) r_lshift <= 1'b0;
                        if (rx_data == SC_RSHIFT) r_rshift <= 1'b0;
                    end
                    S_EXT: r_state <= (rx_data == SC_BREAK) ? S_EXT_BREAK : S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
    // Translation uses the shift/caps state already updated by earlier bytes
    scancode_to_ascii u_xlat (
        .i_code  (r_byte),
        .i_shift (shift_active),
        .i_caps  (r_caps),
        .o_ascii (w_ascii)
    );
    assign w_push  = r_make && (w_ascii != 8'h00);
    assign w_pop   = char_valid & char_ready;
    assign w_full  = (r_count == DEPTH_C);
    assign w_write = w_push && (!w_full || w_pop);
    always_ff @(posedge clk) begin
        if (w_write) r_mem[r_wr] <= w_ascii;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_write) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_count <= r_count + (FIFO_AW + 1)'(w_write) - (FIFO_AW + 1)'(w_pop);
        end
    end
    assign char_valid   = (r_count != '0);
    assign char_data    = char_valid ? r_mem[r_rd] : 8'h00;
    assign shift_active = r_lshift | r_rshift;
    assign caps_active  = r_caps;
    assign overflow     = w_push & w_full & ~w_pop;
    assign fifo_count   = r_count;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: directed table-driven bench plus FIFO/overflow/reset sequences
module tb_ps2_key_decoder;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_strobe = 1'b0;
    logic       rx_err = 1'b0;
    logic [7:0] char_data;
    logic       char_valid;
    logic       char_ready = 1'b0;
    logic       shift_active;
    logic       caps_active;
    logic       overflow;
    logic [3:0] fifo_count;
    int n_chk = 0;
    int n_fail = 0;
    int ovf_cnt = 0;
    typedef struct {
        logic [7:0] data;
        logic       err;
        logic [7:0] ch;
        logic       sh;
        logic       cp;
    } vec_t;
    vec_t tv[$];

    ps2_key_decoder dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_strobe    (rx_strobe),
        .rx_err       (rx_err),
        .char_data    (char_data),
        .char_valid   (char_valid),
        .char_ready   (char_ready),
        .shift_active (shift_active),
        .caps_active  (caps_active),
        .overflow     (overflow),
        .fifo_count   (fifo_count)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (overflow) ovf_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic e);
        rx_data = b;
        rx_err = e;
        rx_strobe = 1'b1;
        @(posedge clk);
        #1;
        rx_strobe = 1'b0;
        rx_err = 1'b0;
    endtask

    task automatic add(input logic [7:0] d, input logic e, input logic [7:0] c, input logic s, input logic k);
        vec_t v;
        v.data = d; v.err = e; v.ch = c; v.sh = s; v.cp = k;
        tv.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        add(8'h1C,0,8'h61,0,0); add(8'hF0,0,8'h00,0,0); add(8'h1C,0,8'h00,0,0);
        add(8'h12,0,8'h00,1,0); add(8'h1C,0,8'h41,1,0); add(8'hF0,0,8'h00,1,0); add(8'h12,0,8'h00,0,0);
        add(8'h58,0,8'h00,0,1); add(8'hF0,0,8'h00,0,1); add(8'h58,0,8'h00,0,1); add(8'h1C,0,8'h41,0,1);
        add(8'h16,0,8'h31,0,1);
        add(8'h12,0,8'h00,1,1); add(8'h1C,0,8'h61,1,1); add(8'h12,0,8'h00,1,1); add(8'h16,0,8'h21,1,1);
        add(8'hE0,0,8'h00,1,1); add(8'h75,0,8'h00,1,1); add(8'hE0,0,8'h00,1,1); add(8'hF0,0,8'h00,1,1);
        add(8'h75,0,8'h00,1,1); add(8'h32,0,8'h62,1,1);
        add(8'hF0,0,8'h00,1,1); add(8'h1C,1,8'h00,1,1); add(8'h1C,0,8'h61,1,1);
        add(8'hF0,0,8'h00,1,1); add(8'h12,0,8'h00,0,1); add(8'h58,0,8'h00,0,0); add(8'hF0,0,8'h00,0,0);
        add(8'h58,0,8'h00,0,0);
        add(8'h29,0,8'h20,0,0); add(8'h5A,0,8'h0D,0,0); add(8'h66,0,8'h08,0,0); add(8'h4E,0,8'h2D,0,0);
        add(8'h59,0,8'h00,1,0); add(8'h4E,0,8'h5F,1,0); add(8'hF0,0,8'h00,1,0); add(8'h59,0,8'h00,0,0);
        add(8'hFA,0,8'h00,0,0); add(8'hE1,0,8'h00,0,0); add(8'h14,0,8'h00,0,0); add(8'h77,0,8'h00,0,0);
        add(8'h1C,0,8'h61,0,0); add(8'h1C,0,8'h61,0,0);

        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", char_valid, 0);
        check("reset_data", char_data, 0);
        check("reset_count", fifo_count, 0);
        check("reset_shift", shift_active, 0);
        check("reset_caps", caps_active, 0);
        check("reset_ovf", overflow, 0);
        reset = 1'b1;
        char_ready = 1'b1;

        foreach (tv[i]) begin
            send(tv[i].data, tv[i].err);
            @(negedge clk);
            check($sformatf("v%0d_shift", i), shift_active, tv[i].sh);
            check($sformatf("v%0d_caps", i), caps_active, tv[i].cp);
            check($sformatf("v%0d_early_valid", i), char_valid, 0);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("v%0d_valid", i), char_valid, tv[i].ch != 8'h00);
            check($sformatf("v%0d_char", i), char_data, tv[i].ch);
            @(posedge clk);
            #1;
        end

        char_ready = 1'b0;
        ovf_cnt = 0;
        repeat (10) send(8'h2C, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("ovf_count_full", fifo_count, 8);
        check("ovf_pulses", ovf_cnt, 2);
        check("ovf_head", char_data, 8'h74);
        send(8'h2C, 1'b0);
        @(negedge clk);
        check("ovf_pulse_now", overflow, 1);
        @(negedge clk);
        check("ovf_pulse_end", overflow, 0);
        check("ovf_count_held", fifo_count, 8);
        @(posedge clk);
        #1;
        char_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("drain_t%0d", i), {char_valid, char_data}, {1'b1, 8'h74});
            @(posedge clk);
        end
        #1;
        check("drain_empty", fifo_count, 0);

        char_ready = 1'b0;
        repeat (8) send(8'h2C, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("pp_full", fifo_count, 8);
        ovf_cnt = 0;
        send(8'h1A, 1'b0);
        char_ready = 1'b1;
        @(negedge clk);
        check("pp_no_ovf", overflow, 0);
        @(posedge clk);
        #1;
        char_ready = 1'b0;
        check("pp_count", fifo_count, 8);
        check("pp_ovf_cnt", ovf_cnt, 0);
        char_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("pp_drain%0d", i), char_data, (i < 7) ? 8'h74 : 8'h7A);
            @(posedge clk);
        end
        repeat (2) @(posedge clk);
        #1;
        check("empty_ready_count", fifo_count, 0);
        check("empty_ready_valid", char_valid, 0);

        char_ready = 1'b0;
        send(8'h58, 1'b0);
        send(8'h1C, 1'b0);
        send(8'hF0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("pre_rst_caps", caps_active, 1);
        check("pre_rst_count", fifo_count, 1);
        check("pre_rst_char", char_data, 8'h41);
        reset = 1'b0;
        #2;
        check("mid_rst_all", {char_valid, char_data, fifo_count, shift_active, caps_active, overflow}, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        send(8'h1C, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_count", fifo_count, 1);
        check("post_rst_char", char_data, 8'h61);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
